// File: rtl/sr_excite_pkg.sv
// ---------------------------------------------------------------------------
// sr_excite_pkg
//  Shared definitions for the SR-based flop banks:
//   - SR input codes {S,R} as seen by one storage bit.
//   - Per-bit excitation functions that map JK, D and T inputs (plus the current
//     bit state where needed) onto an {S,R} pair.
//  No excitation function can produce S=R=1: each pair of terms is gated by Q and ~Q,
//  or by D and ~D, so the two terms never share a true condition.
// ---------------------------------------------------------------------------
package sr_excite_pkg;

   localparam logic [1:0] SR_HOLD = 2'b00;
   localparam logic [1:0] SR_RST  = 2'b01;
   localparam logic [1:0] SR_SET  = 2'b10;
   localparam logic [1:0] SR_ILL  = 2'b11;

   // JK: set only when currently 0, reset only when currently 1, so J=K=1 toggles.
   function automatic logic [1:0] jk2sr(input logic j, input logic k, input logic q);
      return {j & ~q, k & q};
   endfunction

   // D: always either set or reset, the cell simply follows D.
   function automatic logic [1:0] d2sr(input logic d);
      return {d, ~d};
   endfunction

   // T: drive the cell to the opposite of its current value when T=1.
   function automatic logic [1:0] t2sr(input logic t, input logic q);
      return {t & ~q, t & q};
   endfunction

endpackage

// File: rtl/sr_cell.sv
// ---------------------------------------------------------------------------
// sr_cell
//  A WIDTH-bit bank of clocked SR storage bits.
//  Per bit {S,R}: 00 hold, 01 clear, 10 set, 11 hold (illegal, reported on ill_o).
//  Ports:
//   clk_i    rising-edge clock
//   reset_i  synchronous active-high reset, clears the bank
//   s_i      per-bit set inputs
//   r_i      per-bit reset inputs
//   q_o      registered bank state
//   ill_o    combinational s_i & r_i, marks bits currently seeing S=R=1
// ---------------------------------------------------------------------------
module sr_cell
   import sr_excite_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] s_i,
   input  logic [WIDTH-1:0] r_i,
   output logic [WIDTH-1:0] q_o,
   output logic [WIDTH-1:0] ill_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Per-bit SR next-state decode.
   always_comb begin
      q_d = q_q;
      for (int i = 0; i < WIDTH; i++) begin
         case ({s_i[i], r_i[i]})
            SR_HOLD: q_d[i] = q_q[i];
            SR_RST:  q_d[i] = 1'b0;
            SR_SET:  q_d[i] = 1'b1;
            SR_ILL:  q_d[i] = q_q[i];
            default: q_d[i] = q_q[i];
         endcase
      end
   end

   // Bank state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         q_q <= {WIDTH{1'b0}};
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o   = q_q;
   assign ill_o = s_i & r_i;

endmodule

// File: rtl/sr_core_flop_bank.sv
// ---------------------------------------------------------------------------
// sr_core_flop_bank
//  Four WIDTH-bit flop banks built on the common sr_cell storage bank:
//  JK, D and T banks driven through excitation logic, plus one raw SR bank.
//  The raw SR bank is monitored for S=R=1 (sticky per-bit flags and a saturating
//  event counter); the converted banks are monitored for any internal S=R=1,
//  which correct excitation logic never produces.
//  Ports:
//   clk_i           rising-edge clock
//   reset_i         synchronous active-high reset, highest priority
//   j_i, k_i        JK bank inputs
//   d_i             D bank inputs
//   t_i             T bank inputs
//   s_i, r_i        raw SR bank inputs
//   clr_err_i       synchronous clear of counter and sticky flags (not of q_*)
//   q_jk_o .. q_sr_o  bank states
//   illegal_bits_o  sticky per-bit OR of s_i & r_i
//   illegal_cnt_o   cycles with any raw S=R=1, saturating at all-ones
//   conv_err_o      sticky, any converted bank drove S=R=1
// ---------------------------------------------------------------------------
module sr_core_flop_bank
   import sr_excite_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] j_i,
   input  logic [WIDTH-1:0] k_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic [WIDTH-1:0] t_i,
   input  logic [WIDTH-1:0] s_i,
   input  logic [WIDTH-1:0] r_i,
   input  logic             clr_err_i,
   output logic [WIDTH-1:0] q_jk_o,
   output logic [WIDTH-1:0] q_d_o,
   output logic [WIDTH-1:0] q_t_o,
   output logic [WIDTH-1:0] q_sr_o,
   output logic [WIDTH-1:0] illegal_bits_o,
   output logic [CNT_W-1:0] illegal_cnt_o,
   output logic             conv_err_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Excitation signals for each converted bank.
   logic [WIDTH-1:0] s_jk_s, r_jk_s;
   logic [WIDTH-1:0] s_d_s,  r_d_s;
   logic [WIDTH-1:0] s_t_s,  r_t_s;

   // Current bank states and illegal-input markers from the cells.
   logic [WIDTH-1:0] q_jk_s, q_d_s, q_t_s, q_sr_s;
   logic [WIDTH-1:0] ill_jk_s, ill_d_s, ill_t_s, ill_sr_s;

   logic             conv_evt_s;
   logic             sr_evt_s;

   logic [WIDTH-1:0] illegal_bits_q, illegal_bits_d;
   logic [CNT_W-1:0] illegal_cnt_q,  illegal_cnt_d;
   logic             conv_err_q,     conv_err_d;

   // Per-bit excitation for the JK, D and T banks from their own current state.
   always_comb begin
      s_jk_s = {WIDTH{1'b0}};
      r_jk_s = {WIDTH{1'b0}};
      s_d_s  = {WIDTH{1'b0}};
      r_d_s  = {WIDTH{1'b0}};
      s_t_s  = {WIDTH{1'b0}};
      r_t_s  = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         {s_jk_s[i], r_jk_s[i]} = jk2sr(j_i[i], k_i[i], q_jk_s[i]);
         {s_d_s[i],  r_d_s[i]}  = d2sr(d_i[i]);
         {s_t_s[i],  r_t_s[i]}  = t2sr(t_i[i], q_t_s[i]);
      end
   end

   sr_cell #(.WIDTH(WIDTH)) u_cell_jk (
      .clk_i(clk_i), .reset_i(reset_i), .s_i(s_jk_s), .r_i(r_jk_s),
      .q_o(q_jk_s), .ill_o(ill_jk_s)
   );

   sr_cell #(.WIDTH(WIDTH)) u_cell_d (
      .clk_i(clk_i), .reset_i(reset_i), .s_i(s_d_s), .r_i(r_d_s),
      .q_o(q_d_s), .ill_o(ill_d_s)
   );

   sr_cell #(.WIDTH(WIDTH)) u_cell_t (
      .clk_i(clk_i), .reset_i(reset_i), .s_i(s_t_s), .r_i(r_t_s),
      .q_o(q_t_s), .ill_o(ill_t_s)
   );

   // Raw bank: s_i / r_i pass straight through to the cell.
   sr_cell #(.WIDTH(WIDTH)) u_cell_sr (
      .clk_i(clk_i), .reset_i(reset_i), .s_i(s_i), .r_i(r_i),
      .q_o(q_sr_s), .ill_o(ill_sr_s)
   );

   assign conv_evt_s = |(ill_jk_s | ill_d_s | ill_t_s);
   assign sr_evt_s   = |ill_sr_s;

   // Flag next-state: clear (if requested) is applied first, then this cycle's events
   // are recorded on top, so a simultaneous event is never lost.
   always_comb begin
      illegal_bits_d = illegal_bits_q;
      illegal_cnt_d  = illegal_cnt_q;
      conv_err_d     = conv_err_q;
      if (clr_err_i) begin
         illegal_bits_d = {WIDTH{1'b0}};
         illegal_cnt_d  = {CNT_W{1'b0}};
         conv_err_d     = 1'b0;
      end else begin
         illegal_bits_d = illegal_bits_q;
         illegal_cnt_d  = illegal_cnt_q;
         conv_err_d     = conv_err_q;
      end
      illegal_bits_d = illegal_bits_d | ill_sr_s;
      conv_err_d     = conv_err_d | conv_evt_s;
      // Counter sticks at all-ones instead of wrapping.
      if (sr_evt_s && (illegal_cnt_d != CNT_MAX)) begin
         illegal_cnt_d = illegal_cnt_d + CNT_ONE;
      end else begin
         illegal_cnt_d = illegal_cnt_d;
      end
   end

   // Sticky flag and counter registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         illegal_bits_q <= {WIDTH{1'b0}};
         illegal_cnt_q  <= {CNT_W{1'b0}};
         conv_err_q     <= 1'b0;
      end else begin
         illegal_bits_q <= illegal_bits_d;
         illegal_cnt_q  <= illegal_cnt_d;
         conv_err_q     <= conv_err_d;
      end
   end

   assign q_jk_o         = q_jk_s;
   assign q_d_o          = q_d_s;
   assign q_t_o          = q_t_s;
   assign q_sr_o         = q_sr_s;
   assign illegal_bits_o = illegal_bits_q;
   assign illegal_cnt_o  = illegal_cnt_q;
   assign conv_err_o     = conv_err_q;

endmodule

// File: tb/tb_sr_core_flop_bank.sv
// ---------------------------------------------------------------------------
// tb_sr_core_flop_bank
//  Directed, table-driven bench. Two instances share all inputs: the default
//  CNT_W=8 build and a CNT_W=2 build used for counter saturation.
// ---------------------------------------------------------------------------
module tb_sr_core_flop_bank;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset, clr_err;
   logic [W-1:0] j, k, d, t, s, r;

   logic [W-1:0] q_jk, q_d, q_t, q_sr, ill_bits;
   logic [7:0]   ill_cnt;
   logic         conv_err;

   logic [W-1:0] q_jk2, q_d2, q_t2, q_sr2, ill_bits2;
   logic [1:0]   ill_cnt2;
   logic         conv_err2;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sr_core_flop_bank #(.WIDTH(W), .CNT_W(8)) dut (
      .clk_i(clk), .reset_i(reset), .j_i(j), .k_i(k), .d_i(d), .t_i(t),
      .s_i(s), .r_i(r), .clr_err_i(clr_err),
      .q_jk_o(q_jk), .q_d_o(q_d), .q_t_o(q_t), .q_sr_o(q_sr),
      .illegal_bits_o(ill_bits), .illegal_cnt_o(ill_cnt), .conv_err_o(conv_err)
   );

   sr_core_flop_bank #(.WIDTH(W), .CNT_W(2)) dut_sat (
      .clk_i(clk), .reset_i(reset), .j_i(j), .k_i(k), .d_i(d), .t_i(t),
      .s_i(s), .r_i(r), .clr_err_i(clr_err),
      .q_jk_o(q_jk2), .q_d_o(q_d2), .q_t_o(q_t2), .q_sr_o(q_sr2),
      .illegal_bits_o(ill_bits2), .illegal_cnt_o(ill_cnt2), .conv_err_o(conv_err2)
   );

   typedef struct {
      logic         rst;
      logic [W-1:0] j, k, d, t, s, r;
      logic         clr;
      logic [W-1:0] e_jk, e_d, e_t, e_sr, e_bits;
      logic [7:0]   e_cnt;
      logic         e_conv;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic rst_v, input logic [W-1:0] j_v, k_v, d_v, t_v,
                        s_v, r_v, input logic clr_v);
      reset = rst_v; j = j_v; k = k_v; d = d_v; t = t_v; s = s_v; r = r_v;
      clr_err = clr_v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //              rst   j       k       d       t       s       r       clr   | jk      d       t       sr      bits    cnt    conv
      // Reset held two cycles with arbitrary inputs.
      vecs[0]  = '{1'b1, 4'b1111, 4'b0101, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0, 1'b0};
      vecs[1]  = '{1'b1, 4'b0011, 4'b0000, 4'b1010, 4'b0000, 4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0, 1'b0};
      // JK set, D load, T toggles 0->1, SR set bits 2 and 0.
      vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0110, 4'b0011, 4'b0101, 4'b0000, 1'b0, 4'b1111, 4'b0110, 4'b0011, 4'b0101, 4'b0000, 8'd0, 1'b0};
      // JK toggle all, T toggles back, SR holds.
      vecs[3]  = '{1'b0, 4'b1111, 4'b1111, 4'b0110, 4'b0011, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0110, 4'b0000, 4'b0101, 4'b0000, 8'd0, 1'b0};
      // Raw SR s=1100 r=1010 on 0101: bit3 illegal holds 0, bit2 set, bit1 clear, bit0 holds 1.
      vecs[4]  = '{1'b0, 4'b1010, 4'b0101, 4'b1001, 4'b0011, 4'b1100, 4'b1010, 1'b0, 4'b1010, 4'b1001, 4'b0011, 4'b0101, 4'b1000, 8'd1, 1'b0};
      // JK hold with j=k=0, flags sticky.
      vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b1001, 4'b0011, 4'b0101, 4'b1000, 8'd1, 1'b0};
      // clr_err with simultaneous illegal on bit1: clear first, then record.
      vecs[6]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b1, 4'b1010, 4'b0000, 4'b0011, 4'b0101, 4'b0010, 8'd1, 1'b0};
      // Reset mid-operation, inputs ignored.
      vecs[7]  = '{1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0, 1'b0};
      vecs[8]  = '{1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b1000, 4'b0011, 4'b0011, 1'b0, 4'b0101, 4'b0000, 4'b1000, 4'b0000, 4'b0011, 8'd1, 1'b0};
      vecs[9]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0001, 1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 8'd2, 1'b0};
      // Plain clear with no event.
      vecs[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0, 1'b0};
      // JK reset via K, T toggles two bits, SR set bit3.
      vecs[11] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0101, 4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0101, 4'b1000, 4'b0000, 8'd0, 1'b0};

      reset = 1'b1; clr_err = 1'b0;
      j = '0; k = '0; d = '0; t = '0; s = '0; r = '0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst, vecs[i].j, vecs[i].k, vecs[i].d, vecs[i].t,
               vecs[i].s, vecs[i].r, vecs[i].clr);
         chk("q_jk",     i, 32'(q_jk),     32'(vecs[i].e_jk));
         chk("q_d",      i, 32'(q_d),      32'(vecs[i].e_d));
         chk("q_t",      i, 32'(q_t),      32'(vecs[i].e_t));
         chk("q_sr",     i, 32'(q_sr),     32'(vecs[i].e_sr));
         chk("ill_bits", i, 32'(ill_bits), 32'(vecs[i].e_bits));
         chk("ill_cnt",  i, 32'(ill_cnt),  32'(vecs[i].e_cnt));
         chk("conv_err", i, 32'(conv_err), 32'(vecs[i].e_conv));
      end

      // Saturation: s=r=0001 for 5 cycles; CNT_W=2 sticks at 3, CNT_W=8 keeps counting.
      drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      chk("sat_rst_cnt", 0, 32'(ill_cnt2), 32'd0);
      for (int c = 1; c <= 5; c++) begin
         drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0);
         chk("sat_cnt2",  c, 32'(ill_cnt2),  (c > 3) ? 32'd3 : 32'(c));
         chk("sat_cnt8",  c, 32'(ill_cnt),   32'(c));
         chk("sat_bits2", c, 32'(ill_bits2), 32'h1);
         chk("sat_q_sr",  c, 32'(q_sr2),     32'h0);
      end

      // clr_err with simultaneous illegal event on bit1 at saturated counter.
      drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b1);
      chk("clr_cnt2",  6, 32'(ill_cnt2),  32'd1);
      chk("clr_bits2", 6, 32'(ill_bits2), 32'h2);
      chk("clr_cnt8",  6, 32'(ill_cnt),   32'd1);

      // Build some state, then reset wipes everything.
      drive(1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b0);
      chk("pre_q_jk", 7, 32'(q_jk), 32'hF);
      chk("pre_q_sr", 7, 32'(q_sr), 32'hF);
      drive(1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b0);
      chk("rst_q_jk",  8, 32'(q_jk),      32'h0);
      chk("rst_q_d",   8, 32'(q_d),       32'h0);
      chk("rst_q_t",   8, 32'(q_t),       32'h0);
      chk("rst_q_sr",  8, 32'(q_sr),      32'h0);
      chk("rst_bits2", 8, 32'(ill_bits2), 32'h0);
      chk("rst_cnt2",  8, 32'(ill_cnt2),  32'd0);
      chk("rst_conv",  8, 32'(conv_err),  32'd0);
      chk("rst_conv2", 8, 32'(conv_err2), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
